pll_reset_seq: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 23 ++
 rtl/bit_sync.sv | 20 ++
 rtl/pll_reset_seq.sv | 104 ++++++++++
 tb/tb_pll_reset_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAULT
   } seq_state_t;

   localparam int LOSS_CNT_W = 8;

   // Width of the shared phase timer: enough bits to hold the longest count minus one.
   function automatic int timer_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit; async active-high reset clears the chain.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain <= '0;
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset/lock supervisor running on refclk; releases sys_rst after stable lock.
// Optional lock-loss counter enabled by defining PLL_SEQ_LOSS_COUNT_EN.
module pll_reset_seq
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                               refclk,
   input  logic                               rst,
   input  logic                               pll_locked,
   output logic                               pll_rst,
   output logic                               sys_rst,
   output logic                               ready,
   output logic                               fault,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
   output logic [LOSS_CNT_W-1:0]              loss_cnt
);

   localparam int TW = timer_w(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int RW = $clog2(MAX_RETRIES + 1);

   localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

   seq_state_t    state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [RW-1:0] retry_nxt;
   logic          lock_s;

   bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   always_comb begin
      state_nxt = state;
      retry_nxt = retry_cnt;
      timer_nxt = timer;
      case (state)
         PLL_RST:
            if (timer == RST_LAST) state_nxt = WAIT_LOCK;
         WAIT_LOCK:
            // Lock is checked first so a lock arriving on the timeout cycle wins.
            if (lock_s) begin
               state_nxt = STABLE;
            end else if (timer == TIMEOUT_LAST) begin
               if (retry_cnt != RETRY_MAX) retry_nxt = retry_cnt + 1'b1;
               state_nxt = (retry_nxt == RETRY_MAX) ? FAULT : PLL_RST;
            end
         STABLE:
            if (!lock_s)                   state_nxt = WAIT_LOCK;
            else if (timer == STABLE_LAST) state_nxt = RUN;
         RUN:
            if (!lock_s) state_nxt = PLL_RST;
         FAULT:   state_nxt = FAULT;
         default: state_nxt = PLL_RST;
      endcase

      if (state_nxt != state)                   timer_nxt = '0;
      else if (state != RUN && state != FAULT)  timer_nxt = timer + 1'b1;
   end

   // Outputs decode the next state so they change on the same edge as the state.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state     <= PLL_RST;
         timer     <= '0;
         retry_cnt <= '0;
         pll_rst   <= 1'b1;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         retry_cnt <= retry_nxt;
         pll_rst   <= (state_nxt == PLL_RST) || (state_nxt == FAULT);
         sys_rst   <= (state_nxt != RUN);
         ready     <= (state_nxt == RUN);
         fault     <= (state_nxt == FAULT);
      end
   end

`ifdef PLL_SEQ_LOSS_COUNT_EN
   logic lock_lost;
   assign lock_lost = (state == RUN) && !lock_s;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst)                               loss_cnt <= '0;
      else if (lock_lost && loss_cnt != '1)  loss_cnt <= loss_cnt + 1'b1;
   end
`else
   assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Randomised bench for pll_reset_seq: phase-level reference model feeds an output-change scoreboard.
module tb_pll_reset_seq;
   import pll_seq_pkg::*;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int MAX_RETRIES   = 3;
   localparam int SYNC_STAGES   = 2;
   localparam int RW            = $clog2(MAX_RETRIES + 1);
   localparam int VW            = 4 + RW + LOSS_CNT_W;
`ifdef PLL_SEQ_LOSS_COUNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif
   localparam logic [VW-1:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, {RW{1'b0}}, {LOSS_CNT_W{1'b0}}};

   logic                  refclk     = 1'b0;
   logic                  rst        = 1'b0;
   logic                  pll_locked = 1'b0;
   logic                  pll_rst, sys_rst, ready, fault;
   logic [RW-1:0]         retry_cnt;
   logic [LOSS_CNT_W-1:0] loss_cnt;

   pll_reset_seq #(
      .RST_CYCLES    (RST_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .STABLE_CYCLES (STABLE_CYCLES),
      .MAX_RETRIES   (MAX_RETRIES),
      .SYNC_STAGES   (SYNC_STAGES)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .fault      (fault),
      .retry_cnt  (retry_cnt),
      .loss_cnt   (loss_cnt)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      int            cyc;
      logic [VW-1:0] v;
   } ev_t;

   ev_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc    = 0;

   // Reference model: phase of the supervision sequence, edges spent in it, and event counts.
   typedef enum {M_RST, M_WAIT, M_STABLE, M_RUN, M_FAULT} mphase_t;
   mphase_t       m_phase = M_RST;
   int            m_age = 0, m_retries = 0, m_losses = 0;
   bit            m_sh0 = 1'b0, m_sh1 = 1'b0;
   logic [VW-1:0] m_prev = RST_VEC;

   function automatic logic [VW-1:0] model_vec();
      return {(m_phase == M_RST) || (m_phase == M_FAULT), m_phase != M_RUN,
              m_phase == M_RUN, m_phase == M_FAULT, RW'(m_retries), LOSS_CNT_W'(m_losses)};
   endfunction

   function automatic void publish(input int stamp);
      logic [VW-1:0] v;
      v = model_vec();
      if (v !== m_prev) begin
         sb.push_back('{stamp, v});
         m_prev = v;
      end
   endfunction

   function automatic void enter(input mphase_t p);
      m_phase = p;
      m_age   = 0;
   endfunction

   function automatic void model_reset();
      enter(M_RST);
      m_retries = 0;
      m_losses  = 0;
      m_sh0     = 1'b0;
      m_sh1     = 1'b0;
   endfunction

   // lk is the pll_locked level sampled at this edge; decisions use the level two edges old.
   function automatic void model_step(input bit lk);
      bit ls;
      ls    = m_sh1;
      m_sh1 = m_sh0;
      m_sh0 = lk;
      case (m_phase)
         M_RST: begin
            m_age++;
            if (m_age == RST_CYCLES) enter(M_WAIT);
         end
         M_WAIT: begin
            if (ls) enter(M_STABLE);
            else begin
               m_age++;
               if (m_age == LOCK_TIMEOUT) begin
                  m_retries++;
                  if (m_retries == MAX_RETRIES) enter(M_FAULT);
                  else                          enter(M_RST);
               end
            end
         end
         M_STABLE: begin
            if (!ls) enter(M_WAIT);
            else begin
               m_age++;
               if (m_age == STABLE_CYCLES) enter(M_RUN);
            end
         end
         M_RUN: begin
            if (!ls) begin
               if (LOSS_EN && m_losses < 255) m_losses++;
               enter(M_RST);
            end
         end
         default: ;
      endcase
      publish(cyc);
   endfunction

   // Monitor: every change of the DUT output vector must match the next expected event.
   logic [VW-1:0] dut_vec;
   logic [VW-1:0] mon_prev = RST_VEC;
   assign dut_vec = {pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt};

   always @(negedge refclk) begin
      ev_t e;
      if (dut_vec !== mon_prev) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d got=%b required=no change from %b",
                     cyc, dut_vec, mon_prev);
         end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.v !== dut_vec) begin
               errors++;
               $display("FAIL output_event got cyc=%0d vec=%b required cyc=%0d vec=%b",
                        cyc, dut_vec, e.cyc, e.v);
            end
         end
         mon_prev = dut_vec;
      end
   end

   task automatic step(input bit lk);
      pll_locked = lk;
      @(posedge refclk);
      cyc++;
      model_step(lk);
      @(negedge refclk);
   endtask

   // Asserts rst mid-cycle; the monitor sees the change at the next negedge, one edge later.
   task automatic apply_rst(input int hold);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dut_vec !== RST_VEC) begin
         errors++;
         $display("FAIL async_reset got=%b required=%b", dut_vec, RST_VEC);
      end
      model_reset();
      publish(cyc + 1);
      for (int i = 0; i < hold; i++) begin
         @(posedge refclk);
         cyc++;
         @(negedge refclk);
      end
      rst = 1'b0;
   endtask

   task automatic run_to(input mphase_t target, input bit lk, input int budget);
      int n;
      n = 0;
      while (m_phase != target && n < budget) begin
         step(lk);
         n++;
      end
      if (m_phase != target) begin
         checks++;
         errors++;
         $display("FAIL phase_timeout got=%0d required=%0d", m_phase, target);
      end
   endtask

   initial begin
      int g;
      bit lvl;
      int seg;
      #1 rst = 1'b1;
      @(negedge refclk);
      apply_rst(3);

      // Lock 6 edges after pll_rst falls, then hold to RUN.
      for (int n = 0; n < 100 && !(m_phase == M_WAIT && m_age == 6); n++) step(1'b0);
      run_to(M_RUN, 1'b1, 100);
      repeat (5) step(1'b1);

      // No lock: three timeouts into FAULT.
      run_to(M_FAULT, 1'b0, 300);
      repeat (8) step(1'($urandom_range(0, 1)));
      apply_rst(2);

      // Lock arriving on the timeout edge, then one edge too late.
      run_to(M_WAIT, 1'b0, 50);
      while (m_phase == M_WAIT && m_age < LOCK_TIMEOUT - 3) step(1'b0);
      run_to(M_RUN, 1'b1, 100);
      apply_rst(1);
      run_to(M_WAIT, 1'b0, 50);
      while (m_phase == M_WAIT && m_age < LOCK_TIMEOUT - 2) step(1'b0);
      repeat (12) step(1'b1);
      run_to(M_RUN, 1'b1, 100);

      // One-cycle glitch inside STABLE, including the completing edge.
      for (int k = 0; k < 5; k++) begin
         apply_rst(1);
         run_to(M_WAIT, 1'b0, 50);
         repeat ($urandom_range(0, 8)) step(1'b0);
         run_to(M_STABLE, 1'b1, 50);
         g = (k == 0) ? STABLE_CYCLES - 3 : $urandom_range(0, STABLE_CYCLES - 3);
         while (m_phase == M_STABLE && m_age < g) step(1'b1);
         step(1'b0);
         run_to(M_RUN, 1'b1, 200);
      end

      // Lock loss while running.
      for (int k = 0; k < 3; k++) begin
         repeat ($urandom_range(1, 6)) step(1'b1);
         repeat ($urandom_range(1, 4)) step(1'b0);
         run_to(M_RUN, 1'b1, 300);
      end

      // Asynchronous reset mid-RUN and mid-WAIT_LOCK.
      repeat (3) step(1'b1);
      apply_rst($urandom_range(1, 3));
      run_to(M_WAIT, 1'b0, 50);
      repeat ($urandom_range(0, 10)) step(1'b0);
      apply_rst($urandom_range(1, 3));

      // Random lock waveform built from runs of random length.
      for (int k = 0; k < 40; k++) begin
         lvl = ($urandom_range(0, 3) != 0);
         seg = $urandom_range(1, 25);
         repeat (seg) step(lvl);
      end
      apply_rst(2);
      repeat (4) step(1'b0);

      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d pending required=0 next cyc=%0d vec=%b",
                  sb.size(), sb[0].cyc, sb[0].v);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
